// File: rtl/axis_frame_fifo_pkg.sv
// Shared definitions for the AXI-Stream FIFO family: write FSM states and the
// field offsets used to pack one stream beat into a single RAM word.
package axis_frame_fifo_pkg;

   typedef enum logic {
      WR_WRITE = 1'b0,
      WR_DROP  = 1'b1
   } wr_state_e;

   localparam int DATA_OFFSET = 0;

   function automatic int keep_offset(input int data_w);
      return data_w;
   endfunction

   function automatic int last_offset(input int data_w, input int keep_w);
      return data_w + keep_w;
   endfunction

   function automatic int id_offset(input int data_w, input int keep_w);
      return last_offset(data_w, keep_w) + 1;
   endfunction

   function automatic int dest_offset(input int data_w, input int keep_w, input int id_w);
      return id_offset(data_w, keep_w) + id_w;
   endfunction

   function automatic int user_offset(input int data_w, input int keep_w, input int id_w,
                                      input int dest_w);
      return dest_offset(data_w, keep_w, id_w) + dest_w;
   endfunction

   function automatic int fifo_width(input int data_w, input int keep_w, input int id_w,
                                     input int dest_w, input int user_w);
      return user_offset(data_w, keep_w, id_w, dest_w) + user_w;
   endfunction

endpackage

// File: rtl/axis_frame_fifo_if.sv
// AXI-Stream bundle; the master modport drives payload and valid, the slave drives ready.
interface axis_frame_fifo_if #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM with a registered read port; the read register doubles
// as the FIFO output data stage.
module axis_fifo_ram #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]      i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [WIDTH-1:0]      o_rd_data
);
   logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [WIDTH-1:0] r_rd_data;

   // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/axis_frame_fifo.sv
// Single-clock AXI-Stream FIFO with optional store-and-forward frame mode.
// The write head runs ahead of the committed pointer so whole frames can be discarded.
module axis_frame_fifo
   import axis_frame_fifo_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
   parameter int DEPTH          = 1024,
   parameter int ID_WIDTH       = 8,
   parameter int DEST_WIDTH     = 8,
   parameter int USER_WIDTH     = 1,
   parameter int FRAME_FIFO     = 0,
   parameter int DROP_BAD_FRAME = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   axis_frame_fifo_if.slave         s_axis,
   axis_frame_fifo_if.master        m_axis,
   output logic [$clog2(DEPTH):0]   status_depth,
   output logic                     status_overflow,
   output logic                     status_bad_frame,
   output logic                     status_good_frame
);
   localparam int AW        = $clog2(DEPTH);
   localparam int PW        = AW + 1;
   localparam int FW        = fifo_width(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
   localparam int KEEP_OFF  = keep_offset(DATA_WIDTH);
   localparam int LAST_OFF  = last_offset(DATA_WIDTH, KEEP_WIDTH);
   localparam int ID_OFF    = id_offset(DATA_WIDTH, KEEP_WIDTH);
   localparam int DEST_OFF  = dest_offset(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH);
   localparam int USER_OFF  = user_offset(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH, DEST_WIDTH);

   wr_state_e     r_state, w_state_nxt;
   logic [PW-1:0] r_wr_ptr, r_wr_ptr_cur, r_rd_ptr;
   logic [PW-1:0] w_wr_ptr_nxt, w_wr_ptr_cur_nxt, w_rd_ptr_nxt;
   logic [PW-1:0] r_depth;
   logic          r_valid, r_good, r_bad, r_ovf;
   logic          w_good, w_bad, w_ovf;
   logic          w_full_cur, w_empty, w_s_ready, w_accept, w_we, w_load;
   logic [FW-1:0] w_wr_data, w_rd_data;

   assign w_full_cur = (r_wr_ptr_cur - r_rd_ptr) == PW'(DEPTH);
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_s_ready  = !rst && ((FRAME_FIFO != 0) || !w_full_cur);
   assign w_accept   = s_axis.tvalid && w_s_ready;
   assign w_load     = !w_empty && (!r_valid || m_axis.tready);
   assign w_rd_ptr_nxt = w_load ? r_rd_ptr + PW'(1) : r_rd_ptr;

   always_comb begin
      w_wr_data = '0;
      w_wr_data[DATA_OFFSET +: DATA_WIDTH] = s_axis.tdata;
      w_wr_data[KEEP_OFF +: KEEP_WIDTH]    = s_axis.tkeep;
      w_wr_data[LAST_OFF]                  = s_axis.tlast;
      w_wr_data[ID_OFF +: ID_WIDTH]        = s_axis.tid;
      w_wr_data[DEST_OFF +: DEST_WIDTH]    = s_axis.tdest;
      w_wr_data[USER_OFF +: USER_WIDTH]    = s_axis.tuser;
   end

   // NOTE: every output of this block is defaulted first so no path leaves a value unassigned (no latches).
   always_comb begin
      w_state_nxt      = r_state;
      w_wr_ptr_nxt     = r_wr_ptr;
      w_wr_ptr_cur_nxt = r_wr_ptr_cur;
      w_we             = 1'b0;
      w_good           = 1'b0;
      w_bad            = 1'b0;
      w_ovf            = 1'b0;
      if (FRAME_FIFO == 0) begin
         if (w_accept) begin
            w_we             = 1'b1;
            w_wr_ptr_cur_nxt = r_wr_ptr_cur + PW'(1);
            w_wr_ptr_nxt     = r_wr_ptr_cur + PW'(1);
         end
      end else begin
         case (r_state)
            WR_WRITE: begin
               if (w_accept && w_full_cur) begin
                  // Frame cannot fit: rewind to the last commit and swallow the rest.
                  w_wr_ptr_cur_nxt = r_wr_ptr;
                  if (s_axis.tlast) w_ovf = 1'b1;
                  else              w_state_nxt = WR_DROP;
               end else if (w_accept) begin
                  w_we             = 1'b1;
                  w_wr_ptr_cur_nxt = r_wr_ptr_cur + PW'(1);
                  if (s_axis.tlast) begin
                     if ((DROP_BAD_FRAME != 0) && s_axis.tuser[0]) begin
                        w_wr_ptr_cur_nxt = r_wr_ptr;
                        w_bad            = 1'b1;
                     end else begin
                        w_wr_ptr_nxt = r_wr_ptr_cur + PW'(1);
                        w_good       = 1'b1;
                     end
                  end
               end
            end
            WR_DROP: begin
               if (w_accept && s_axis.tlast) begin
                  w_ovf       = 1'b1;
                  w_state_nxt = WR_WRITE;
               end
            end
            default: w_state_nxt = WR_WRITE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= WR_WRITE;
         r_wr_ptr     <= '0;
         r_wr_ptr_cur <= '0;
         r_rd_ptr     <= '0;
         r_depth      <= '0;
         r_valid      <= 1'b0;
         r_good       <= 1'b0;
         r_bad        <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_ptr     <= w_wr_ptr_nxt;
         r_wr_ptr_cur <= w_wr_ptr_cur_nxt;
         r_rd_ptr     <= w_rd_ptr_nxt;
         r_depth      <= w_wr_ptr_nxt - w_rd_ptr_nxt;
         r_good       <= w_good;
         r_bad        <= w_bad;
         r_ovf        <= w_ovf;
         if (w_load)              r_valid <= 1'b1;
         else if (m_axis.tready)  r_valid <= 1'b0;
      end
   end

   axis_fifo_ram #(
      .WIDTH      (FW),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_we),
      .i_wr_addr (r_wr_ptr_cur[AW-1:0]),
      .i_wr_data (w_wr_data),
      .i_rd_en   (w_load),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (w_rd_data)
   );

   assign s_axis.tready     = w_s_ready;
   assign m_axis.tvalid     = r_valid;
   assign m_axis.tdata      = w_rd_data[DATA_OFFSET +: DATA_WIDTH];
   assign m_axis.tkeep      = w_rd_data[KEEP_OFF +: KEEP_WIDTH];
   assign m_axis.tlast      = w_rd_data[LAST_OFF];
   assign m_axis.tid        = w_rd_data[ID_OFF +: ID_WIDTH];
   assign m_axis.tdest      = w_rd_data[DEST_OFF +: DEST_WIDTH];
   assign m_axis.tuser      = w_rd_data[USER_OFF +: USER_WIDTH];
   assign status_depth      = r_depth;
   assign status_good_frame = r_good;
   assign status_bad_frame  = r_bad;
   assign status_overflow   = r_ovf;
endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench: instance A is a plain FIFO (cycle table + random streaming), instance B
// is a store-and-forward FIFO with bad-frame drop (frame, overflow, reset sequences).
module tb_axis_frame_fifo;
   localparam int DW = 16, KW = 2, IW = 4, DSW = 4, UW = 1, PW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic [PW-1:0] dep_a, dep_b;
   logic ovf_a, bad_a, good_a, ovf_b, bad_b, good_b;

   axis_frame_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) sa ();
   axis_frame_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) ma ();
   axis_frame_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) sb ();
   axis_frame_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) mb ();

   axis_frame_fifo #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(8), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
      .USER_WIDTH(UW), .FRAME_FIFO(0), .DROP_BAD_FRAME(0)
   ) u_a (
      .clk(clk), .rst(rst_a), .s_axis(sa), .m_axis(ma), .status_depth(dep_a),
      .status_overflow(ovf_a), .status_bad_frame(bad_a), .status_good_frame(good_a)
   );

   axis_frame_fifo #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(8), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
      .USER_WIDTH(UW), .FRAME_FIFO(1), .DROP_BAD_FRAME(1)
   ) u_b (
      .clk(clk), .rst(rst_b), .s_axis(sb), .m_axis(mb), .status_depth(dep_b),
      .status_overflow(ovf_b), .status_bad_frame(bad_b), .status_good_frame(good_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- instance A cycle table ----------------
   typedef struct packed {
      logic          sv;
      logic [15:0]   sd;
      logic          mr;
      logic          e_sr;
      logic          e_mv;
      logic [15:0]   e_md;
      logic [PW-1:0] e_dep;
   } vec_t;

   function automatic vec_t mk(input logic sv, input logic [15:0] sd, input logic mr,
                               input logic e_sr, input logic e_mv, input logic [15:0] e_md,
                               input int e_dep);
      vec_t v;
      v.sv = sv; v.sd = sd; v.mr = mr;
      v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_dep = PW'(e_dep);
      return v;
   endfunction

   // ---------------- instance B monitor and helpers ----------------
   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  k;
      logic        l;
      logic [3:0]  id;
      logic [3:0]  de;
      logic        u;
   } beat_t;

   beat_t q_b[$];
   int    n_good = 0, n_bad = 0, n_ovf = 0;

   always @(negedge clk) begin
      if (mb.tvalid && mb.tready)
         q_b.push_back({mb.tdata, mb.tkeep, mb.tlast, mb.tid, mb.tdest, mb.tuser});
      if (good_b) n_good++;
      if (bad_b)  n_bad++;
      if (ovf_b)  n_ovf++;
   end

   function automatic beat_t exp_beat(input logic [7:0] tag, input int i, input int n);
      beat_t b;
      b.d  = {tag, 8'(i)};
      b.k  = (i == n - 1) ? 2'b01 : 2'b11;
      b.l  = (i == n - 1);
      b.id = tag[3:0];
      b.de = ~tag[3:0];
      b.u  = 1'b0;
      return b;
   endfunction

   task automatic tick(input int c);
      repeat (c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat_b(input logic [7:0] tag, input int i, input int n, input logic bad);
      beat_t b;
      b = exp_beat(tag, i, n);
      sb.tvalid = 1'b1;
      sb.tdata  = b.d;
      sb.tkeep  = b.k;
      sb.tlast  = b.l;
      sb.tid    = b.id;
      sb.tdest  = b.de;
      sb.tuser  = bad && b.l;
      tick(1);
      sb.tvalid = 1'b0;
   endtask

   task automatic send_frame_b(input logic [7:0] tag, input int n, input logic bad);
      for (int i = 0; i < n; i++) beat_b(tag, i, n, bad);
   endtask

   task automatic expect_frame(input string name, input logic [7:0] tag, input int n);
      check({name, "_count"}, q_b.size(), n);
      for (int i = 0; i < n && i < q_b.size(); i++)
         check($sformatf("%s_beat%0d", name, i), q_b[i], exp_beat(tag, i, n));
      q_b.delete();
   endtask

   initial begin
      vec_t tbl[22];
      int   sent, recv, cyc;
      logic hs_in, hs_out;
      logic [15:0] got;

      tbl[0]  = mk(1, 16'hA000, 0, 1, 0, 16'h0000, 0);
      tbl[1]  = mk(1, 16'hA001, 0, 1, 0, 16'h0000, 1);
      tbl[2]  = mk(1, 16'hA002, 0, 1, 1, 16'hA000, 1);
      tbl[3]  = mk(1, 16'hA003, 0, 1, 1, 16'hA000, 2);
      tbl[4]  = mk(1, 16'hA004, 0, 1, 1, 16'hA000, 3);
      tbl[5]  = mk(1, 16'hA005, 0, 1, 1, 16'hA000, 4);
      tbl[6]  = mk(1, 16'hA006, 0, 1, 1, 16'hA000, 5);
      tbl[7]  = mk(1, 16'hA007, 0, 1, 1, 16'hA000, 6);
      tbl[8]  = mk(1, 16'hA008, 0, 1, 1, 16'hA000, 7);
      tbl[9]  = mk(1, 16'hA009, 0, 0, 1, 16'hA000, 8);
      tbl[10] = mk(1, 16'hA009, 0, 0, 1, 16'hA000, 8);
      tbl[11] = mk(1, 16'hA009, 1, 0, 1, 16'hA000, 8);
      tbl[12] = mk(1, 16'hA009, 1, 1, 1, 16'hA001, 7);
      tbl[13] = mk(0, 16'h0000, 1, 1, 1, 16'hA002, 7);
      tbl[14] = mk(0, 16'h0000, 1, 1, 1, 16'hA003, 6);
      tbl[15] = mk(0, 16'h0000, 1, 1, 1, 16'hA004, 5);
      tbl[16] = mk(0, 16'h0000, 1, 1, 1, 16'hA005, 4);
      tbl[17] = mk(0, 16'h0000, 1, 1, 1, 16'hA006, 3);
      tbl[18] = mk(0, 16'h0000, 1, 1, 1, 16'hA007, 2);
      tbl[19] = mk(0, 16'h0000, 1, 1, 1, 16'hA008, 1);
      tbl[20] = mk(0, 16'h0000, 1, 1, 1, 16'hA009, 0);
      tbl[21] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 0);

      rst_a = 1'b1; rst_b = 1'b1;
      sa.tvalid = 0; sa.tdata = '0; sa.tkeep = 2'b11; sa.tlast = 0; sa.tid = '0; sa.tdest = '0; sa.tuser = '0;
      sb.tvalid = 0; sb.tdata = '0; sb.tkeep = '0;    sb.tlast = 0; sb.tid = '0; sb.tdest = '0; sb.tuser = '0;
      ma.tready = 0; mb.tready = 0;
      tick(2);

      check("rst_a_s_ready", sa.tready, 0);
      check("rst_a_m_valid", ma.tvalid, 0);
      check("rst_a_m_data",  ma.tdata, 0);
      check("rst_a_depth",   dep_a, 0);
      check("rst_b_s_ready", sb.tready, 0);
      check("rst_b_events",  {good_b, bad_b, ovf_b}, 0);
      rst_a = 1'b0; rst_b = 1'b0;

      // A: fill against a stalled sink, then drain in order.
      for (int k = 0; k < 22; k++) begin
         sa.tvalid = tbl[k].sv; sa.tdata = tbl[k].sd; ma.tready = tbl[k].mr;
         #1;
         check($sformatf("a_row%0d_s_ready", k), sa.tready, tbl[k].e_sr);
         check($sformatf("a_row%0d_m_valid", k), ma.tvalid, tbl[k].e_mv);
         check($sformatf("a_row%0d_depth", k),   dep_a, tbl[k].e_dep);
         if (tbl[k].e_mv) check($sformatf("a_row%0d_m_data", k), ma.tdata, tbl[k].e_md);
         tick(1);
      end
      check("a_no_events", {good_a, bad_a, ovf_a}, 0);

      // A: 1000 beats with random sink stalls across many pointer wraps.
      sent = 0; recv = 0; cyc = 0;
      while (recv < 1000 && cyc < 20000) begin
         sa.tvalid = (sent < 1000);
         sa.tdata  = 16'(sent);
         ma.tready = 1'($urandom_range(0, 1));
         #1;
         hs_in  = sa.tvalid && sa.tready;
         hs_out = ma.tvalid && ma.tready;
         got    = ma.tdata;
         tick(1);
         if (hs_in) sent++;
         if (hs_out) begin
            check("a_stream_data", got, 64'(16'(recv)));
            recv++;
         end
         cyc++;
      end
      check("a_stream_count", recv, 1000);
      sa.tvalid = 0; ma.tready = 1;
      tick(3);
      check("a_stream_no_extra", ma.tvalid, 0);
      check("a_stream_depth",    dep_a, 0);

      // B: 4-beat frame stays invisible until one cycle after its tlast edge.
      mb.tready = 1;
      #1;
      check("b_s_ready", sb.tready, 1);
      for (int i = 0; i < 4; i++) begin
         beat_b(8'h21, i, 4, 1'b0);
         check($sformatf("b_f1_hidden%0d", i), mb.tvalid, 0);
      end
      check("b_f1_good_pulse", good_b, 1);
      check("b_f1_depth", dep_b, 4);
      tick(1);
      check("b_f1_visible", mb.tvalid, 1);
      check("b_f1_head", {mb.tdata, mb.tkeep, mb.tlast, mb.tid, mb.tdest, mb.tuser}, exp_beat(8'h21, 0, 4));
      tick(6);
      expect_frame("b_f1", 8'h21, 4);
      check("b_f1_good_count", n_good, 1);
      check("b_f1_drained", mb.tvalid, 0);

      // B: 12-beat frame overflows an 8-deep buffer.
      send_frame_b(8'h33, 12, 1'b0);
      check("b_ovf_pulse", ovf_b, 1);
      check("b_ovf_depth", dep_b, 0);
      tick(3);
      check("b_ovf_no_output", q_b.size(), 0);
      check("b_ovf_count", n_ovf, 1);
      send_frame_b(8'h34, 3, 1'b0);
      tick(6);
      expect_frame("b_after_ovf", 8'h34, 3);
      check("b_after_ovf_good", n_good, 2);

      // B: bad frame is dropped, next frame unaffected.
      send_frame_b(8'h45, 5, 1'b1);
      check("b_bad_pulse", bad_b, 1);
      check("b_bad_depth", dep_b, 0);
      tick(3);
      check("b_bad_no_output", q_b.size(), 0);
      check("b_bad_count", n_bad, 1);
      send_frame_b(8'h46, 2, 1'b0);
      tick(6);
      expect_frame("b_after_bad", 8'h46, 2);
      check("b_after_bad_good", n_good, 3);
      check("b_ovf_count_final", n_ovf, 1);

      // B: reset with 3 committed beats and a partial frame in flight.
      mb.tready = 0;
      send_frame_b(8'h57, 3, 1'b0);
      beat_b(8'h58, 0, 5, 1'b0);
      beat_b(8'h58, 1, 5, 1'b0);
      check("b_pre_rst_valid", mb.tvalid, 1);
      check("b_pre_rst_depth", dep_b, 2);
      rst_b = 1'b1;
      #1;
      check("b_rst_valid", mb.tvalid, 0);
      check("b_rst_depth", dep_b, 0);
      check("b_rst_s_ready", sb.tready, 0);
      check("b_rst_data", mb.tdata, 0);
      tick(1);
      rst_b = 1'b0;
      mb.tready = 1;
      check("b_rst_nothing_out", q_b.size(), 0);
      send_frame_b(8'h69, 3, 1'b0);
      tick(6);
      expect_frame("b_post_rst", 8'h69, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
